// File: rtl/mmio_lsu_if.sv
// rtl/mmio_lsu_if.sv - core-side request/response bus of the load/store unit
interface mmio_lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  code;
  logic [2:0]  io_code;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, code, io_code,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, code, io_code,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mmio_lsu.sv
// rtl/mmio_lsu.sv - byte/half/word load-store unit for data SRAM and memory-mapped LEDs, HEX, switches, buttons
module mmio_lsu #(
  parameter int DMEM_AW = 11,
  parameter int SW_W    = 18,
  parameter int BTN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mmio_lsu_if.slave        bus,
  input  logic [SW_W-1:0]  sw_i,
  input  logic [BTN_W-1:0] btn_i,
  output logic [31:0]      ledr_o,
  output logic [31:0]      ledg_o,
  output logic [31:0]      hex_lo_o,
  output logic [31:0]      hex_hi_o
);

  logic [31:0] mem [0:(1<<DMEM_AW)-1];

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]         off;
  logic [2:0]         f3;
  logic [DMEM_AW-1:0] idx;
  logic               acc_err, do_store, sram_sel, mem_we;
  logic [3:0]         be;
  logic [31:0]        wrep, rd_word, shifted;

  wire unused_addr_hi = ^bus.req_addr[31:DMEM_AW+2];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    off = bus.req_addr[1:0];
    f3  = bus.req_funct3;
    idx = bus.req_addr[DMEM_AW+1:2];

    // Illegal encodings, misalignment, stores of unsigned types and instruction/reserved regions
    acc_err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
           || ((f3[1:0] == 2'b01) && off[0])
           || ((f3 == 3'b010) && (off != 2'b00))
           || (bus.req_we && f3[2])
           || (bus.code == 2'd1) || (bus.code == 2'd3);

    case (f3[1:0])
      2'b00:   begin be = 4'b0001 << off; wrep = {4{bus.req_wdata[7:0]}};  end
      2'b01:   begin be = 4'b0011 << off; wrep = {2{bus.req_wdata[15:0]}}; end
      default: begin be = 4'b1111;        wrep = bus.req_wdata;            end
    endcase

    sram_sel = (bus.io_code == 3'd0) && (bus.code == 2'd2);
    do_store = bus.req_valid && bus.req_we && !acc_err;
    mem_we   = do_store && sram_sel;

    case (bus.io_code)
      3'd1:    rd_word = {{(32-BTN_W){1'b0}}, btn_s2_q};
      3'd2:    rd_word = {{(32-SW_W){1'b0}}, sw_s2_q};
      3'd3:    rd_word = hex_hi_q;
      3'd4:    rd_word = hex_lo_q;
      3'd5:    rd_word = ledg_q;
      3'd6:    rd_word = ledr_q;
      3'd0:    rd_word = sram_sel ? mem[idx] : 32'h0;
      default: rd_word = 32'h0;
    endcase
    shifted = rd_word >> {off, 3'b000};

    ledr_d   = (do_store && bus.io_code == 3'd6) ? merge(ledr_q, wrep, be)   : ledr_q;
    ledg_d   = (do_store && bus.io_code == 3'd5) ? merge(ledg_q, wrep, be)   : ledg_q;
    hex_lo_d = (do_store && bus.io_code == 3'd4) ? merge(hex_lo_q, wrep, be) : hex_lo_q;
    hex_hi_d = (do_store && bus.io_code == 3'd3) ? merge(hex_hi_q, wrep, be) : hex_hi_q;

    rsp_valid_d = bus.req_valid;
    rsp_err_d   = bus.req_valid && acc_err;
    rsp_rdata_d = 32'h0;
    if (bus.req_valid && !bus.req_we && !acc_err) begin
      case (f3)
        3'b000:  rsp_rdata_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  rsp_rdata_d = {24'h0, shifted[7:0]};
        3'b001:  rsp_rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  rsp_rdata_d = {16'h0, shifted[15:0]};
        default: rsp_rdata_d = shifted;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      ledr_q      <= 32'h0;
      ledg_q      <= 32'h0;
      hex_lo_q    <= 32'h0;
      hex_hi_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      sw_s1_q     <= sw_i;
      sw_s2_q     <= sw_s1_q;
      btn_s1_q    <= btn_i;
      btn_s2_q    <= btn_s1_q;
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      hex_lo_q    <= hex_lo_d;
      hex_hi_q    <= hex_hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ledr_o        = ledr_q;
  assign ledg_o        = ledg_q;
  assign hex_lo_o      = hex_lo_q;
  assign hex_hi_o      = hex_hi_q;

endmodule

// File: tb/tb_mmio_lsu.sv
// tb/tb_mmio_lsu.sv - directed self-checking bench for mmio_lsu
module tb_mmio_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] sw_i = '0;
  logic [3:0]  btn_i = '0;
  logic [31:0] ledr_o, ledg_o, hex_lo_o, hex_hi_o;
  int checks = 0;
  int errors = 0;

  mmio_lsu_if bus();

  mmio_lsu #(.DMEM_AW(11), .SW_W(18), .BTN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sw_i     (sw_i),
    .btn_i    (btn_i),
    .ledr_o   (ledr_o),
    .ledg_o   (ledg_o),
    .hex_lo_o (hex_lo_o),
    .hex_hi_o (hex_hi_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] cd, input logic [2:0] io);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.code       = cd;
    bus.io_code    = io;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic [31:0] exp_data, input logic exp_err);
    chk({tag, "_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
    chk({tag, "_err"},   {31'h0, bus.rsp_err},   {31'h0, exp_err});
    chk({tag, "_data"},  bus.rsp_rdata,          exp_data);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.code = 2'd0; bus.io_code = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("reset_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_ledr", ledr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, LW, 32'h7000, 32'hCAFEF00D, 2'd0, 3'd6);
    rsp("sw_ledr0", 32'h0, 1'b0);
    chk("ledr0", ledr_o, 32'hCAFEF00D);
    do_req(1'b0, LW, 32'h7000, 32'h0, 2'd0, 3'd6);
    rsp("lw_ledr0", 32'hCAFEF00D, 1'b0);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("midrst_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_ledr", ledr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_valid", {31'h0, bus.rsp_valid}, 32'h0);

    do_req(1'b1, LW, 32'h2004, 32'hDEADBEEF, 2'd2, 3'd0);
    rsp("sw_2004", 32'h0, 1'b0);
    do_req(1'b0, LW, 32'h2004, 32'h0, 2'd2, 3'd0);
    rsp("lw_2004", 32'hDEADBEEF, 1'b0);
    do_req(1'b1, LW, 32'h2000, 32'hDEADBEEF, 2'd2, 3'd0);
    do_req(1'b1, LB, 32'h2001, 32'h00000080, 2'd2, 3'd0);
    rsp("sb_2001", 32'h0, 1'b0);
    do_req(1'b0, LB, 32'h2001, 32'h0, 2'd2, 3'd0);
    rsp("lb_2001", 32'hFFFFFF80, 1'b0);
    do_req(1'b0, LBU, 32'h2001, 32'h0, 2'd2, 3'd0);
    rsp("lbu_2001", 32'h00000080, 1'b0);
    do_req(1'b0, LHU, 32'h2000, 32'h0, 2'd2, 3'd0);
    rsp("lhu_2000", 32'h000080EF, 1'b0);
    do_req(1'b0, LH, 32'h2000, 32'h0, 2'd2, 3'd0);
    rsp("lh_2000", 32'hFFFF80EF, 1'b0);
    do_req(1'b0, LH, 32'h2002, 32'h0, 2'd2, 3'd0);
    rsp("lh_2002", 32'hFFFFDEAD, 1'b0);

    do_req(1'b0, LW, 32'h2002, 32'h0, 2'd2, 3'd0);
    rsp("lw_mis", 32'h0, 1'b1);
    do_req(1'b1, LH, 32'h2003, 32'h00001234, 2'd2, 3'd0);
    rsp("sh_mis", 32'h0, 1'b1);
    do_req(1'b1, LBU, 32'h2000, 32'h00000011, 2'd2, 3'd0);
    rsp("sbu_bad", 32'h0, 1'b1);
    do_req(1'b0, 3'b011, 32'h2000, 32'h0, 2'd2, 3'd0);
    rsp("f3_011", 32'h0, 1'b1);
    do_req(1'b0, LW, 32'h2000, 32'h0, 2'd2, 3'd0);
    rsp("lw_2000", 32'hDEAD80EF, 1'b0);
    do_req(1'b0, LW, 32'h0000, 32'h0, 2'd2, 3'd0);
    rsp("lw_alias", 32'hDEAD80EF, 1'b0);

    do_req(1'b1, LW, 32'h7000, 32'h12345678, 2'd0, 3'd6);
    chk("ledr1", ledr_o, 32'h12345678);
    do_req(1'b1, LB, 32'h7022, 32'h0000003F, 2'd0, 3'd4);
    rsp("sb_hex", 32'h0, 1'b0);
    chk("hex_lo", hex_lo_o, 32'h003F0000);
    chk("hex_hi", hex_hi_o, 32'h0);
    do_req(1'b0, LBU, 32'h7022, 32'h0, 2'd0, 3'd4);
    rsp("lbu_hex", 32'h0000003F, 1'b0);
    do_req(1'b1, LW, 32'h7010, 32'hFFFFFFFF, 2'd0, 3'd2);
    rsp("sw_switch", 32'h0, 1'b0);
    chk("ledr_kept", ledr_o, 32'h12345678);
    do_req(1'b0, LW, 32'h9000, 32'h0, 2'd0, 3'd0);
    rsp("lw_unmapped", 32'h0, 1'b0);

    @(negedge clk);
    bus.req_valid = 1'b0;
    sw_i  = 18'h002A5;
    btn_i = 4'hA;
    @(posedge clk);
    #1;
    do_req(1'b0, LW, 32'h7010, 32'h0, 2'd0, 3'd2);
    rsp("sync_1edge", 32'h0, 1'b0);
    do_req(1'b0, LW, 32'h7010, 32'h0, 2'd0, 3'd2);
    rsp("sync_2edge", 32'h000002A5, 1'b0);
    do_req(1'b0, LW, 32'h7000, 32'h0, 2'd0, 3'd1);
    rsp("btn", 32'h0000000A, 1'b0);
    do_req(1'b0, LW, 32'h0100, 32'h0, 2'd1, 3'd0);
    rsp("lw_imem", 32'h0, 1'b1);

    idle();
    chk("idle_valid", {31'h0, bus.rsp_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
